// File: rtl/stream_pack_upsizer.sv
// stream_pack_upsizer: packs up to Ratio narrow beats into one wide word.
// The word sits upstream of a slow two-phase CDC source port, so each
// handshake there carries Ratio beats instead of one.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   clr_i                sync clear, drops all buffered state
//   in_data_i/last/valid narrow input stream, in_ready_o back-pressure
//   out_data_o           packed word, slot k at [k*NarrowWidth +: NarrowWidth]
//   out_strb_o           per-slot valid mask (contiguous from bit 0)
//   out_last_o           word holds the packet's last beat
//   out_valid_o/ready_i  wide output handshake
//
// in_ready_o depends only on registers, so there is no combinational path
// from out_ready_i back to the input side.

// One accumulator slot: holds one beat plus its strobe bit.
module stream_pack_upsizer_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         strb_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= '0;
      strb_o <= 1'b0;
    end else if (clr_i) begin
      data_o <= '0;
      strb_o <= 1'b0;
    end else if (wr_i) begin
      data_o <= data_i;
      strb_o <= 1'b1;
    end
  end
endmodule

module stream_pack_upsizer #(
  parameter int unsigned NarrowWidth = 8,
  parameter int unsigned Ratio       = 4,
  parameter int unsigned CntWidth    = $clog2(Ratio)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic [NarrowWidth-1:0]       in_data_i,
  input  logic                         in_last_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [NarrowWidth*Ratio-1:0] out_data_o,
  output logic [Ratio-1:0]             out_strb_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);
  typedef logic [Ratio-1:0][NarrowWidth-1:0] word_t;

  // accumulator
  word_t               slot_data;
  logic [Ratio-1:0]    slot_strb;
  logic [Ratio-1:0]    slot_wr;
  logic                acc_last;
  logic                acc_done;
  logic [CntWidth-1:0] cnt;

  // output register
  word_t               out_data;
  logic [Ratio-1:0]    out_strb;
  logic                out_last;
  logic                out_valid;

  // merged view: accumulator with the current beat already in its slot
  word_t               mrg_data;
  logic [Ratio-1:0]    mrg_strb;
  logic                mrg_last;

  logic accept, completing, out_free, load_beat, load_acc, load;

  assign in_ready_o = ~acc_done;
  assign accept     = in_valid_i & in_ready_o & ~clr_i;
  assign completing = accept & ((cnt == CntWidth'(Ratio-1)) | in_last_i);
  assign out_free   = ~out_valid | out_ready_i;
  // load_beat and load_acc are exclusive: acc_done blocks accept.
  assign load_beat  = completing & out_free;
  assign load_acc   = acc_done & out_free & ~clr_i;
  assign load       = load_beat | load_acc;

  for (genvar k = 0; k < Ratio; k++) begin : g_slot
    assign slot_wr[k]  = accept & (cnt == CntWidth'(k));
    assign mrg_data[k] = slot_wr[k] ? in_data_i : slot_data[k];
    assign mrg_strb[k] = slot_wr[k] | slot_strb[k];

    // Clearing on load wins over the write: a beat that completes a word
    // bypasses the slot straight into the output register.
    stream_pack_upsizer_slot #(.W(NarrowWidth)) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i | load),
      .wr_i   (slot_wr[k]),
      .data_i (in_data_i),
      .data_o (slot_data[k]),
      .strb_o (slot_strb[k])
    );
  end

  assign mrg_last = acc_last | (accept & in_last_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else if (clr_i) begin
      cnt      <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else begin
      if (accept) cnt <= completing ? '0 : cnt + CntWidth'(1);
      if (load)                       acc_last <= 1'b0;
      else if (accept & in_last_i)    acc_last <= 1'b1;
      if (load_acc)                   acc_done <= 1'b0;
      else if (completing & ~out_free) acc_done <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr_i) begin
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= mrg_data;
      out_strb  <= mrg_strb;
      out_last  <= mrg_last;
      out_valid <= 1'b1;
    end else if (out_valid & out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data_o  = out_data;
  assign out_strb_o  = out_strb;
  assign out_last_o  = out_last;
  assign out_valid_o = out_valid;
endmodule

// File: tb/tb_stream_pack_upsizer.sv
module tb_stream_pack_upsizer;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr_i;
  logic [7:0]  in_data_i;
  logic        in_last_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_strb_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int checks = 0;
  int errors = 0;

  stream_pack_upsizer #(.NarrowWidth(8), .Ratio(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // drive one beat for one edge, then return with #1 settle after the edge
  task automatic send(input logic [7:0] d, input logic l);
    in_data_i = d; in_last_i = l; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d,
                          input logic [3:0] s, input logic l);
    chk({tag, "_valid"}, {31'b0, out_valid_o}, 32'd1);
    chk({tag, "_data"},  out_data_o, d);
    chk({tag, "_strb"},  {28'b0, out_strb_o}, {28'b0, s});
    chk({tag, "_last"},  {31'b0, out_last_o}, {31'b0, l});
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
    chk("rst_data",  out_data_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // full word, output drains immediately
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk("full_notyet", {31'b0, out_valid_o}, 32'd0);
    send(8'h44, 1'b0);
    chk_word("full", 32'h44332211, 4'b1111, 1'b0);
    tick();
    chk("full_onecyc", {31'b0, out_valid_o}, 32'd0);

    // partial word flushed by last, then next packet starts at slot 0
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    chk_word("partial", 32'h0000BBAA, 4'b0011, 1'b1);
    send(8'h77, 1'b1);
    chk_word("slot0", 32'h00000077, 4'b0001, 1'b1);
    tick();

    // last on slot Ratio-1
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b1);
    chk_word("last3", 32'hC4C3C2C1, 4'b1111, 1'b1);
    tick();

    // back-pressure: two words, second held in accumulator
    out_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk_word("bp_hold", 32'h04030201, 4'b1111, 1'b0);
    chk("bp_inrdy", {31'b0, in_ready_o}, 32'd0);
    tick();
    chk_word("bp_stable", 32'h04030201, 4'b1111, 1'b0);
    chk("bp_inrdy2", {31'b0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    tick();
    chk_word("bp_second", 32'h08070605, 4'b1111, 1'b0);
    chk("bp_inrdy3", {31'b0, in_ready_o}, 32'd1);
    tick();
    chk("bp_drain", {31'b0, out_valid_o}, 32'd0);

    // single beat with last
    send(8'h5A, 1'b1);
    chk_word("single", 32'h0000005A, 4'b0001, 1'b1);
    tick();

    // clear drops a partial word
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr_valid", {31'b0, out_valid_o}, 32'd0);
    chk("clr_ready", {31'b0, in_ready_o}, 32'd1);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
    chk("clr_notrace", {31'b0, out_valid_o}, 32'd0);
    send(8'h40, 1'b0);
    chk_word("clr_word", 32'h40302010, 4'b1111, 1'b0);
    tick();

    // async reset mid-stream with a held word and a partial word
    out_ready_i = 1'b0;
    send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
    chk_word("rst_held", 32'hE4E3E2E1, 4'b1111, 1'b0);
    send(8'hF1, 1'b0); send(8'hF2, 1'b0);
    #2 rst_ni = 1'b0;
    #1 chk("arst_valid", {31'b0, out_valid_o}, 32'd0);
    #1 rst_ni = 1'b1;
    tick();
    chk("arst_after_valid", {31'b0, out_valid_o}, 32'd0);
    chk("arst_after_ready", {31'b0, in_ready_o}, 32'd1);
    out_ready_i = 1'b1;
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    chk("arst_nospur", {31'b0, out_valid_o}, 32'd0);
    send(8'hA4, 1'b0);
    chk_word("arst_clean", 32'hA4A3A2A1, 4'b1111, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
